ifu_imem_rsp: RTL and testbench
===============================

# ifu_imem_rsp

Instruction-memory responder for the IFU fetch channel: accepts one `ifu_req_pc` at a time on the REQ channel and drives the fetched word back on the RSP channel. It sits between the IFU fetch stage and a single-port synchronous SRAM. It inserts programmable wait states and flags misaligned or out-of-range fetches. It is the memory-side counterpart of the fetch initiator.

## Interface
- `MEM_AW`, 14: SRAM word-address width; window size is 4·2^MEM_AW bytes.
- `BASE`, `PC_SIZE'h8000_0000`: byte base address of the window.
- `WAIT_CYC`, 0: fixed wait states inserted before the SRAM read, 0..15.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `ifu_req_valid`  in  1  fetch request valid.
- `ifu_req_ready`  out  1  responder can accept a request.
- `ifu_req_pc`  in  `PC_SIZE`  fetch byte address.
- `ifu_rsp_valid`  out  1  response valid.
- `ifu_rsp_ready`  in  1  IFU accepts the response.
- `ifu_rsp_instr`  out  `INSTR_SIZE`  fetched instruction.
- `ifu_rsp_err`  out  1  fetch fault; `ifu_rsp_instr` is 0 when set.
- `sram_cs`  out  1  SRAM read strobe, single cycle.
- `sram_addr`  out  `MEM_AW`  SRAM word address.
- `sram_rdata`  in  `INSTR_SIZE`  read data, valid in the cycle after `sram_cs`.

## Operation
- States: IDLE, WAIT, CAPTURE, ERR.
- Request handshake: `hs_req = ifu_req_valid & ifu_req_ready`.
- Response handshake: `hs_rsp = ifu_rsp_valid & ifu_rsp_ready`.
- `ifu_req_ready = rst & (state==IDLE) & (~rsp_full | hs_rsp)`. A request is accepted in the same cycle the previous response drains.
- IDLE, on `hs_req`:
  - Latch `sram_addr <= pc[MEM_AW+1:2]`.
  - Load `cnt <= WAIT_CYC (+ rnd)`.
  - Fault check: `pc[1:0]!=0`, or `pc-BASE >= 4·2^MEM_AW` (unsigned `PC_SIZE`-bit subtraction, so pc<BASE wraps and faults).
  - Fault → ERR; otherwise → WAIT.
- WAIT:
  - `cnt!=0`: decrement; `sram_cs=0`.
  - `cnt==0`: `sram_cs=1` for this cycle; → CAPTURE.
- CAPTURE: load the response register (`instr <= sram_rdata`, `err <= 0`, `rsp_full <= 1`); → IDLE.
- ERR: no `sram_cs`; load the response register (`instr <= 0`, `err <= 1`, `rsp_full <= 1`); → IDLE.
- Response register:
  - `ifu_rsp_valid = rsp_full`.
  - Cleared on `hs_rsp` unless it is reloaded in the same cycle (a reload wins).
  - Contents are held stable while `valid & ~ready`.
- Reset values (`rst` low, any state, including mid-transaction): state IDLE, `cnt` 0, `rsp_full` 0, `ifu_rsp_instr` 0, `ifu_rsp_err` 0, `sram_addr` 0, `sram_cs` 0, `ifu_req_ready` 0. An in-flight transaction is dropped with no response.

## Timing
- T = cycle of `hs_req`; W = total wait states.
- Normal fetch:
  - `sram_cs` high in cycle T+1+W.
  - `sram_rdata` is sampled in T+2+W.
  - `ifu_rsp_valid` first high in T+3+W.
- Faulted fetch: `ifu_rsp_valid` first high in T+2; `sram_cs` never asserted.
- Throughput with `ifu_rsp_ready` tied high: one response every 3+W cycles. The next request may handshake in the same cycle as the previous `hs_rsp`.
- A stalled response (`ifu_rsp_ready` low) holds `ifu_req_ready` low indefinitely. No request is ever dropped or duplicated.

## Configuration
- Macro: `IMEM_RAND_WAIT_EN`.
- Defined:
  - 4-bit LFSR, polynomial x^4+x^3+1, reset seed 4'b1001, advances every cycle.
  - `rnd = lfsr[1:0]` is sampled at `hs_req`; W = WAIT_CYC + rnd (0..3 extra).
  - Used to stress the IFU handshake.
- Undefined: no LFSR; W = WAIT_CYC exactly.

## Test plan
- Reset, then single fetch (WAIT_CYC=0, macro off):
  - Stimulus: SRAM word 0 = 32'h0000_0413; request pc=32'h8000_0000, rsp_ready=1.
  - `sram_cs` at T+1 with addr 0.
  - Response at T+3: instr 32'h0000_0413, err 0, valid for one cycle.
- Wait states: WAIT_CYC=3, pc=32'h8000_0008 → `sram_cs` at T+4 with addr 2; `ifu_rsp_valid` at T+6.
- Faults:
  - pc=32'h8000_0002 → valid at T+2, err=1, instr=0, no `sram_cs`.
  - pc=32'h7FFF_FFFC → same fault response.
  - pc=BASE+4·2^MEM_AW → same fault response.
- Backpressure:
  - Hold `ifu_rsp_ready`=0 for 10 cycles after valid: instr/err stable, `ifu_req_ready`=0 throughout.
  - Raise ready together with a new request: handshake in the same cycle; next response valid 3 cycles later.
- Reset mid-op: drop `rst` in the WAIT cycle of a WAIT_CYC=2 fetch → next cycle all outputs at reset values; after release, a fresh fetch completes normally with no stale response.
- `IMEM_RAND_WAIT_EN` defined:
  - 200 back-to-back fetches with random `ifu_rsp_ready`.
  - Every latency within [3, 6] cycles, data in request order, 200 responses exactly.

Source files
------------

// File: rtl/ifu_imem_rsp_if.sv
// IFU fetch channel between the fetch initiator (master) and the instruction-memory
// responder (slave): REQ carries the fetch PC, RSP returns the instruction word and fault flag.
interface ifu_imem_rsp_if #(
    parameter int unsigned PC_SIZE    = 32,
    parameter int unsigned INSTR_SIZE = 32
);
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [PC_SIZE-1:0]    ifu_req_pc;
    logic                  ifu_rsp_valid;
    logic                  ifu_rsp_ready;
    logic [INSTR_SIZE-1:0] ifu_rsp_instr;
    logic                  ifu_rsp_err;

    modport master (
        output ifu_req_valid,
        output ifu_req_pc,
        output ifu_rsp_ready,
        input  ifu_req_ready,
        input  ifu_rsp_valid,
        input  ifu_rsp_instr,
        input  ifu_rsp_err
    );

    modport slave (
        input  ifu_req_valid,
        input  ifu_req_pc,
        input  ifu_rsp_ready,
        output ifu_req_ready,
        output ifu_rsp_valid,
        output ifu_rsp_instr,
        output ifu_rsp_err
    );
endinterface

// File: rtl/ifu_imem_rsp.sv
// Instruction-memory responder: accepts one fetch at a time, inserts wait states, reads a
// single-port synchronous SRAM and returns the word (or a fault) through a response register.
// Optional feature macro: IMEM_RAND_WAIT_EN adds 0..3 pseudo-random wait states per fetch.
module ifu_imem_rsp #(
    parameter int unsigned        PC_SIZE    = 32,
    parameter int unsigned        INSTR_SIZE = 32,
    parameter int unsigned        MEM_AW     = 14,
    parameter logic [PC_SIZE-1:0] BASE       = PC_SIZE'('h8000_0000),
    parameter int unsigned        WAIT_CYC   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    ifu_imem_rsp_if.slave         ifu,
    output logic                  sram_cs_o,
    output logic [MEM_AW-1:0]     sram_addr_o,
    input  logic [INSTR_SIZE-1:0] sram_rdata_i
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StWait    = 2'd1;
    localparam logic [1:0] StCapture = 2'd2;
    localparam logic [1:0] StErr     = 2'd3;

    // Window size in bytes; MEM_AW + 2 must stay below PC_SIZE.
    localparam logic [PC_SIZE-1:0] WinBytes = PC_SIZE'(1) << (MEM_AW + 2);

    logic [1:0]            state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [MEM_AW-1:0]     addr_q, addr_d;
    logic                  rsp_full_q, rsp_full_d;
    logic [INSTR_SIZE-1:0] instr_q, instr_d;
    logic                  err_q, err_d;

    logic                  hs_req;
    logic                  hs_rsp;
    logic                  fault;
    logic [PC_SIZE-1:0]    pc_off;
    logic [4:0]            wait_ld;

    assign hs_rsp            = rsp_full_q & ifu.ifu_rsp_ready;
    // A new request may be taken in the same cycle the pending response drains.
    assign ifu.ifu_req_ready = rst_ni & (state_q == StIdle) & (~rsp_full_q | hs_rsp);
    assign hs_req            = ifu.ifu_req_valid & ifu.ifu_req_ready;

    // Unsigned wrap makes a PC below BASE land far outside the window.
    assign pc_off = ifu.ifu_req_pc - BASE;
    assign fault  = (ifu.ifu_req_pc[1:0] != 2'b00) | (pc_off >= WinBytes);

    assign ifu.ifu_rsp_valid = rsp_full_q;
    assign ifu.ifu_rsp_instr = instr_q;
    assign ifu.ifu_rsp_err   = err_q;
    assign sram_addr_o       = addr_q;
    assign sram_cs_o         = rst_ni & (state_q == StWait) & (cnt_q == 5'd0);

`ifdef IMEM_RAND_WAIT_EN
    logic [3:0] lfsr_q;

    // Free-running x^4+x^3+1 LFSR supplying 0..3 extra wait states.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lfsr_q <= 4'b1001;
        end else begin
            lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        end
    end

    assign wait_ld = 5'(WAIT_CYC) + {3'b000, lfsr_q[1:0]};
`else
    assign wait_ld = 5'(WAIT_CYC);
`endif

    // Next-state logic for the fetch sequencer and the response register.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rsp_full_d = rsp_full_q;
        instr_d    = instr_q;
        err_d      = err_q;

        // Drain first so a reload below wins in the same cycle.
        if (hs_rsp) begin
            rsp_full_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (hs_req) begin
                    addr_d  = ifu.ifu_req_pc[MEM_AW+1:2];
                    cnt_d   = wait_ld;
                    state_d = fault ? StErr : StWait;
                end
            end
            StWait: begin
                if (cnt_q != 5'd0) begin
                    cnt_d = cnt_q - 5'd1;
                end else begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                instr_d    = sram_rdata_i;
                err_d      = 1'b0;
                rsp_full_d = 1'b1;
                state_d    = StIdle;
            end
            StErr: begin
                instr_d    = '0;
                err_d      = 1'b1;
                rsp_full_d = 1'b1;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset drops any in-flight fetch.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= 5'd0;
            addr_q     <= '0;
            rsp_full_q <= 1'b0;
            instr_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rsp_full_q <= rsp_full_d;
            instr_q    <= instr_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_ifu_imem_rsp.sv
// Bench for ifu_imem_rsp: a zero-wait instance checked by a queue scoreboard under directed
// and random traffic, plus a three-wait-state instance for wait timing and mid-fetch reset.
module tb_ifu_imem_rsp;

    localparam int unsigned MEM_AW = 14;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          WC0    = 0;
    localparam int          WCW    = 3;
`ifdef IMEM_RAND_WAIT_EN
    localparam int          RND_MAX = 3;
`else
    localparam int          RND_MAX = 0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic        err;
        bit          fault;
        int          t;
    } exp_t;

    typedef struct {
        logic [13:0] addr;
        int          t;
    } cs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs   = 0;
    int checks = 0;

    logic rst_n0 = 1'b0;
    logic rst_nw = 1'b0;

    ifu_imem_rsp_if #(.PC_SIZE(32), .INSTR_SIZE(32)) ifu0 ();
    ifu_imem_rsp_if #(.PC_SIZE(32), .INSTR_SIZE(32)) ifuw ();

    logic        sram_cs0, sram_csw;
    logic [13:0] sram_addr0, sram_addrw;
    logic [31:0] sram_rdata0, sram_rdataw;

    ifu_imem_rsp #(.MEM_AW(MEM_AW), .BASE(BASE), .WAIT_CYC(WC0)) u_dut0 (
        .clk_i        (clk),
        .rst_ni       (rst_n0),
        .ifu          (ifu0),
        .sram_cs_o    (sram_cs0),
        .sram_addr_o  (sram_addr0),
        .sram_rdata_i (sram_rdata0)
    );

    ifu_imem_rsp #(.MEM_AW(MEM_AW), .BASE(BASE), .WAIT_CYC(WCW)) u_dutw (
        .clk_i        (clk),
        .rst_ni       (rst_nw),
        .ifu          (ifuw),
        .sram_cs_o    (sram_csw),
        .sram_addr_o  (sram_addrw),
        .sram_rdata_i (sram_rdataw)
    );

    // Memory contents as a closed-form function of the word address; word 0 is 32'h0000_0413.
    function automatic logic [31:0] mem_word(input logic [13:0] a);
        return (32'(a) * 32'h0001_0003) ^ 32'h0000_0413;
    endfunction

    // Synchronous SRAM models: data appears the cycle after the strobe.
    always @(posedge clk) if (sram_cs0) sram_rdata0 <= mem_word(sram_addr0);
    always @(posedge clk) if (sram_csw) sram_rdataw <= mem_word(sram_addrw);

    // Reference fault rule: misaligned, or outside [BASE, BASE + 4*2^MEM_AW).
    function automatic bit is_fault(input logic [31:0] pc);
        longint unsigned p, lo, hi;
        p  = longint'(pc);
        lo = longint'(BASE);
        hi = lo + 4 * (longint'(1) << MEM_AW);
        return (pc % 4 != 0) || (p < lo) || (p >= hi);
    endfunction

    function automatic logic [13:0] word_idx(input logic [31:0] pc);
        return 14'((pc / 4) % (32'd1 << MEM_AW));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errs++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d..%0d", name, cyc, act, lo, hi);
        end
    endtask

    // ---------------- scoreboard for u_dut0 ----------------
    exp_t exp_q[$];
    cs_t  cs_q[$];
    bit   mon0 = 1'b0;
    bit   seen = 1'b0;
    bit   rdy_exp;
    exp_t me;
    cs_t  mc;
    logic [31:0] held_instr;
    logic        held_err;
    int   n_rsp = 0;
    int   last_hs_rsp = -1;

    bit rdy_rand = 1'b0;
    bit rdy_ctl  = 1'b1;

    // Sole driver of the zero-wait instance's rsp_ready: directed level or random.
    initial forever begin
        ifu0.ifu_rsp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_ctl;
        @(posedge clk);
        #2;
    end

    always @(negedge clk) begin
        if (mon0) begin
            rdy_exp = (exp_q.size() == 0) ||
                      (exp_q.size() == 1 && ifu0.ifu_rsp_valid && ifu0.ifu_rsp_ready);
            chk("req_ready", 32'(ifu0.ifu_req_ready), 32'(rdy_exp));

            if (sram_cs0) begin
                checks++;
                if (cs_q.size() == 0) begin
                    errs++;
                    $display("FAIL sram_cs_unexpected @cyc %0d: got cs=1 expected cs=0", cyc);
                end else begin
                    mc = cs_q.pop_front();
                    chk("sram_addr", 32'(sram_addr0), 32'(mc.addr));
                    chk_rng("cs_latency", cyc - mc.t, 1 + WC0, 1 + WC0 + RND_MAX);
                end
            end

            if (!ifu0.ifu_rsp_valid && seen) begin
                checks++;
                errs++;
                $display("FAIL valid_dropped @cyc %0d: got valid=0 expected valid=1", cyc);
                seen = 1'b0;
            end

            if (ifu0.ifu_rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_rsp @cyc %0d: got valid=1 expected valid=0", cyc);
                end else begin
                    me = exp_q[0];
                    if (!seen) begin
                        seen = 1'b1;
                        if (me.fault) chk_rng("fault_latency", cyc - me.t, 2, 2);
                        else chk_rng("rsp_latency", cyc - me.t, 3 + WC0, 3 + WC0 + RND_MAX);
                    end else begin
                        chk("hold_instr", ifu0.ifu_rsp_instr, held_instr);
                        chk("hold_err", 32'(ifu0.ifu_rsp_err), 32'(held_err));
                    end
                    held_instr = ifu0.ifu_rsp_instr;
                    held_err   = ifu0.ifu_rsp_err;
                    if (ifu0.ifu_rsp_ready) begin
                        chk("rsp_instr", ifu0.ifu_rsp_instr, me.instr);
                        chk("rsp_err", 32'(ifu0.ifu_rsp_err), 32'(me.err));
                        void'(exp_q.pop_front());
                        n_rsp++;
                        last_hs_rsp = cyc;
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    // Issue one fetch on u_dut0; entered and left just after a rising edge.
    task automatic issue0(input logic [31:0] pc, output int t);
        exp_t e;
        cs_t  c;
        bit   done;
        done = 1'b0;
        t    = -1;
        ifu0.ifu_req_valid = 1'b1;
        ifu0.ifu_req_pc    = pc;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            #1;
            if (ifu0.ifu_req_ready) begin
                done    = 1'b1;
                t       = cyc;
                e.fault = is_fault(pc);
                e.err   = e.fault;
                e.instr = e.fault ? 32'd0 : mem_word(word_idx(pc));
                e.t     = cyc;
                exp_q.push_back(e);
                if (!e.fault) begin
                    c.addr = word_idx(pc);
                    c.t    = cyc;
                    cs_q.push_back(c);
                end
            end
            @(posedge clk);
            #1;
        end
        chk("req_handshake", 32'(done), 32'd1);
        ifu0.ifu_req_valid = 1'b0;
    endtask

    task automatic drain0(input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            #1;
            ok = (exp_q.size() == 0) && !ifu0.ifu_rsp_valid;
        end
        chk("drain", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        int r;
        r  = int'($urandom_range(0, 7));
        pc = BASE + ($urandom_range(0, (1 << MEM_AW) - 1) << 2);
        if (r == 0) pc = pc + $urandom_range(1, 3);
        else if (r == 1) pc = BASE - 4 * $urandom_range(1, 64);
        else if (r == 2) pc = BASE + (32'd4 << MEM_AW) + 4 * $urandom_range(0, 64);
        return pc;
    endfunction

    // One fetch on the wait-state instance, recording strobe and response timing.
    task automatic run_w(input logic [31:0] pc, input int n, output int cs_at,
                         output logic [13:0] cs_addr, output int v_at,
                         output logic [31:0] v_instr, output logic v_err);
        int t;
        t = -1; cs_at = -1; v_at = -1; cs_addr = '0; v_instr = '0; v_err = 1'b0;
        ifuw.ifu_req_valid = 1'b1;
        ifuw.ifu_req_pc    = pc;
        for (int k = 0; k < 20 && t < 0; k++) begin
            @(negedge clk);
            if (ifuw.ifu_req_ready) t = cyc;
            @(posedge clk);
            #1;
        end
        chk("w_req_handshake", 32'(t >= 0), 32'd1);
        ifuw.ifu_req_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (sram_csw && cs_at < 0) begin
                cs_at   = cyc - t;
                cs_addr = sram_addrw;
            end
            if (ifuw.ifu_rsp_valid && v_at < 0) begin
                v_at    = cyc - t;
                v_instr = ifuw.ifu_rsp_instr;
                v_err   = ifuw.ifu_rsp_err;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        int base_n;
        int cs_at, v_at;
        logic [13:0] cs_addr;
        logic [31:0] v_instr;
        logic v_err;

        ifu0.ifu_req_valid = 1'b0;
        ifu0.ifu_req_pc    = '0;
        ifuw.ifu_req_valid = 1'b0;
        ifuw.ifu_req_pc    = '0;
        ifuw.ifu_rsp_ready = 1'b1;
        sram_rdata0        = '0;
        sram_rdataw        = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(ifu0.ifu_req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(ifu0.ifu_rsp_valid), 32'd0);
        chk("rst_rsp_instr", ifu0.ifu_rsp_instr, 32'd0);
        chk("rst_rsp_err", 32'(ifu0.ifu_rsp_err), 32'd0);
        chk("rst_sram_cs", 32'(sram_cs0), 32'd0);
        chk("rst_sram_addr", 32'(sram_addr0), 32'd0);
        @(posedge clk);
        #1;
        rst_n0 = 1'b1;
        rst_nw = 1'b1;
        mon0   = 1'b1;

        // Single fetch, then the fault cases and the top word of the window.
        issue0(BASE, t);
        drain0(20);
        issue0(32'h8000_0002, t);
        drain0(20);
        issue0(32'h7FFF_FFFC, t);
        drain0(20);
        issue0(BASE + (32'd4 << MEM_AW), t);
        drain0(20);
        issue0(BASE + (32'd4 << MEM_AW) - 32'd4, t);
        drain0(20);

        // Backpressure: hold the response for 10 cycles, then release with a new request.
        rdy_ctl = 1'b0;
        issue0(32'h8000_0010, t);
        for (int k = 0; k < 30 && !ifu0.ifu_rsp_valid; k++) @(negedge clk);
        chk("bp_valid_seen", 32'(ifu0.ifu_rsp_valid), 32'd1);
        for (int k = 0; k < 10; k++) begin
            chk("bp_req_ready_low", 32'(ifu0.ifu_req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rdy_ctl = 1'b1;
        issue0(32'h8000_0014, t);
        chk("bp_same_cycle_hs", 32'(t), 32'(last_hs_rsp));
        drain0(20);

        // Random back-to-back traffic with random response backpressure.
        rdy_rand = 1'b1;
        base_n   = n_rsp;
        for (int i = 0; i < 200; i++) issue0(rand_pc(), t);
        drain0(200);
        rdy_rand = 1'b0;
        chk("rsp_count", 32'(n_rsp - base_n), 32'd200);

        // Wait-state instance: strobe and response timing.
        run_w(32'h8000_0008, 14, cs_at, cs_addr, v_at, v_instr, v_err);
        chk_rng("w_cs_latency", cs_at, 1 + WCW, 1 + WCW + RND_MAX);
        chk("w_cs_addr", 32'(cs_addr), 32'd2);
        chk("w_rsp_latency", 32'(v_at), 32'(cs_at + 2));
        chk("w_rsp_instr", v_instr, mem_word(14'd2));
        chk("w_rsp_err", 32'(v_err), 32'd0);

        // Reset during the WAIT phase: outputs clear, no stale response afterwards.
        ifuw.ifu_req_valid = 1'b1;
        ifuw.ifu_req_pc    = 32'h8000_0004;
        @(negedge clk);
        chk("w_req_ready_idle", 32'(ifuw.ifu_req_ready), 32'd1);
        @(posedge clk);
        #1;
        ifuw.ifu_req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_nw = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("w_rst_req_ready", 32'(ifuw.ifu_req_ready), 32'd0);
        chk("w_rst_rsp_valid", 32'(ifuw.ifu_rsp_valid), 32'd0);
        chk("w_rst_rsp_instr", ifuw.ifu_rsp_instr, 32'd0);
        chk("w_rst_rsp_err", 32'(ifuw.ifu_rsp_err), 32'd0);
        chk("w_rst_sram_cs", 32'(sram_csw), 32'd0);
        chk("w_rst_sram_addr", 32'(sram_addrw), 32'd0);
        @(posedge clk);
        #1;
        rst_nw = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("w_no_stale_valid", 32'(ifuw.ifu_rsp_valid), 32'd0);
            chk("w_no_stale_cs", 32'(sram_csw), 32'd0);
        end
        @(posedge clk);
        #1;
        run_w(32'h8000_000C, 14, cs_at, cs_addr, v_at, v_instr, v_err);
        chk_rng("w2_cs_latency", cs_at, 1 + WCW, 1 + WCW + RND_MAX);
        chk("w2_cs_addr", 32'(cs_addr), 32'd3);
        chk("w2_rsp_latency", 32'(v_at), 32'(cs_at + 2));
        chk("w2_rsp_instr", v_instr, mem_word(14'd3));
        chk("w2_rsp_err", 32'(v_err), 32'd0);

        mon0 = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog @cyc %0d: got no completion expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
